intra_recon: RTL

INTRA_RECON -- requirements
Module: intra_recon

---
 rtl/intra_recon_pkg.sv | 18 +
 rtl/intra_recon_clip.sv | 32 +++
 rtl/intra_recon.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/intra_recon_pkg.sv
// Shared types and helpers for the intra reconstruction block: FSM states,
// TU size limits and the per-side 4x4 block count of a TU.
package intra_recon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] TU_SIZE_MIN = 3'd2;
    localparam logic [2:0] TU_SIZE_MAX = 3'd5;

    // Number of 4x4 blocks along one side of a TU of log2 size tu (2..5).
    function automatic logic [3:0] blk_count(input logic [2:0] tu);
        blk_count = 4'd1 << (tu - TU_SIZE_MIN);
    endfunction

endpackage

// File: rtl/intra_recon_clip.sv
// One-sample reconstruction: pred + signed residual, clipped to the sample range.
// Optional clipped flag under INTRA_RECON_CLIP_CNT_EN.
module intra_recon_clip #(
    parameter int BIT_DEPTH = 8
) (
    input  logic [BIT_DEPTH-1:0] pred,
    input  logic [BIT_DEPTH:0]   resid,
`ifdef INTRA_RECON_CLIP_CNT_EN
    output logic                 clipped,
`endif
    output logic [BIT_DEPTH-1:0] recon
);

    logic signed [BIT_DEPTH+1:0] sum_s;

    // Sum at BIT_DEPTH+2 bits: the top bit is the sign, the next one flags overflow.
    always_comb begin
        sum_s = $signed({2'b00, pred}) + $signed({resid[BIT_DEPTH], resid});
        if (sum_s[BIT_DEPTH+1]) begin
            recon = {BIT_DEPTH{1'b0}};
        end else if (sum_s[BIT_DEPTH]) begin
            recon = {BIT_DEPTH{1'b1}};
        end else begin
            recon = sum_s[BIT_DEPTH-1:0];
        end
    end

`ifdef INTRA_RECON_CLIP_CNT_EN
    assign clipped = sum_s[BIT_DEPTH+1] | sum_s[BIT_DEPTH];
`endif

endmodule

// File: rtl/intra_recon.sv
// Intra TU reconstruction: walks the 4x4 blocks of a TU in raster order and
// registers clipped pred+resid per block. INTRA_RECON_CLIP_CNT_EN adds clip_cnt.
module intra_recon
    import intra_recon_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [2:0]                  tuSize,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [16*BIT_DEPTH-1:0]     pred,
    input  logic [16*(BIT_DEPTH+1)-1:0] resid,
    input  logic                        bStop,
    output logic                        out_valid,
    output logic [16*BIT_DEPTH-1:0]     reconSamples,
    output logic [2:0]                  X,
    output logic [2:0]                  Y,
    output logic                        isLastCycInTb,
    output logic                        busy
`ifdef INTRA_RECON_CLIP_CNT_EN
    ,
    output logic [15:0]                 clip_cnt
`endif
);

    localparam int SW = BIT_DEPTH;
    localparam int RW = BIT_DEPTH + 1;

    state_e              state_q, state_d;
    logic [2:0]          tu_q, tu_d;
    logic [2:0]          col_q, col_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          x_q, x_d;
    logic [2:0]          y_q, y_d;
    logic                out_valid_q, out_valid_d;
    logic                last_q, last_d;
    logic [16*SW-1:0]    recon_q, recon_d;
    logic [16*SW-1:0]    clip_s;
    logic                accept_s;
    logic                last_blk_s;
    logic                tu_legal_s;
    logic [2:0]          n_last_s;

`ifdef INTRA_RECON_CLIP_CNT_EN
    logic [15:0]         flags_s;
    logic [15:0]         cnt_q, cnt_d;
    logic [4:0]          pop_s;
    logic [16:0]         cnt_sum_s;
`endif

    for (genvar i = 0; i < 16; i++) begin : g_clip
        intra_recon_clip #(.BIT_DEPTH(BIT_DEPTH)) u_clip (
            .pred    (pred[(15-i)*SW +: SW]),
            .resid   (resid[(15-i)*RW +: RW]),
`ifdef INTRA_RECON_CLIP_CNT_EN
            .clipped (flags_s[i]),
`endif
            .recon   (clip_s[(15-i)*SW +: SW])
        );
    end

    // Handshake and end-of-TU detection from the current counters.
    always_comb begin
        tu_legal_s = (tuSize >= TU_SIZE_MIN) && (tuSize <= TU_SIZE_MAX);
        n_last_s   = 3'(blk_count(tu_q) - 4'd1);
        last_blk_s = (col_q == n_last_s) && (row_q == n_last_s);
        in_ready   = (state_q == RUN) && (!out_valid_q || !bStop);
        accept_s   = in_valid && in_ready;
    end

    // Next-state for FSM, block counters and output register; rst_n clears synchronously.
    always_comb begin
        state_d     = state_q;
        tu_d        = tu_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        recon_d     = recon_q;
        x_d         = x_q;
        y_d         = y_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                if (start && tu_legal_s) begin
                    state_d = RUN;
                    tu_d    = tuSize;
                    col_d   = 3'd0;
                    row_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s && last_blk_s) begin
                    state_d = IDLE;
                    col_d   = 3'd0;
                    row_d   = 3'd0;
                end else if (accept_s && (col_q == n_last_s)) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                end else if (accept_s) begin
                    col_d = col_q + 3'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new block always wins; otherwise an unstalled output drains.
        if (accept_s) begin
            out_valid_d = 1'b1;
            recon_d     = clip_s;
            x_d         = col_q;
            y_d         = row_q;
            last_d      = last_blk_s;
        end else if (out_valid_q && !bStop) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (!rst_n) begin
            state_d     = IDLE;
            tu_d        = 3'd0;
            col_d       = 3'd0;
            row_d       = 3'd0;
            out_valid_d = 1'b0;
            recon_d     = {16*SW{1'b0}};
            x_d         = 3'd0;
            y_d         = 3'd0;
            last_d      = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            tu_q        <= 3'd0;
            col_q       <= 3'd0;
            row_q       <= 3'd0;
            out_valid_q <= 1'b0;
            recon_q     <= {16*SW{1'b0}};
            x_q         <= 3'd0;
            y_q         <= 3'd0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tu_q        <= tu_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            recon_q     <= recon_d;
            x_q         <= x_d;
            y_q         <= y_d;
            last_q      <= last_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign reconSamples  = recon_q;
    assign X             = x_q;
    assign Y             = y_q;
    assign isLastCycInTb = last_q;
    assign busy          = (state_q == RUN) || out_valid_q;

`ifdef INTRA_RECON_CLIP_CNT_EN
    // Saturating count of clipped samples, cleared when a TU is started.
    always_comb begin
        pop_s = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop_s = pop_s + {4'd0, flags_s[i]};
        end
        cnt_sum_s = {1'b0, cnt_q} + {12'd0, pop_s};
        if (!rst_n) begin
            cnt_d = 16'd0;
        end else if (start && (state_q == IDLE)) begin
            cnt_d = 16'd0;
        end else if (accept_s && cnt_sum_s[16]) begin
            cnt_d = 16'hFFFF;
        end else if (accept_s) begin
            cnt_d = cnt_sum_s[15:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Clip counter register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clip_cnt = cnt_q;
`endif

endmodule
